// File: rtl/bp_be_issue_queue.sv
// Purpose: rollback-capable multi-lane instruction queue between the FE queue handshake and BE dispatch.
// Latency: an entry enqueued at edge t is visible on v_o/data_o after edge t (no same-cycle bypass).
// Backpressure: ready_o drops when issued-but-uncommitted plus unissued entries fill all slots; commits free them.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   data_i, v_i, ready_o    enqueue side (enqueue when v_i & ready_o)
//   data_o, v_o             lanes_p oldest speculative entries, v_o thermometer-coded
//   yumi_cnt_i              lanes consumed (issued) this cycle
//   deq_cnt_i               oldest issued entries committed this cycle
//   roll_i                  replay: speculative pointer returns to the commit pointer
//   clr_i                   discard every entry
//   empty_o, full_o         no speculative entries / no free slot
//   credits_o               free slots
module bp_be_issue_queue #(
  parameter int data_width_p = 64,
  parameter int els_p        = 16,
  parameter int lanes_p      = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [data_width_p-1:0]           data_i,
  input  logic                              v_i,
  output logic                              ready_o,
  output logic [lanes_p*data_width_p-1:0]   data_o,
  output logic [lanes_p-1:0]                v_o,
  input  logic [$clog2(lanes_p+1)-1:0]      yumi_cnt_i,
  input  logic [$clog2(lanes_p+1)-1:0]      deq_cnt_i,
  input  logic                              roll_i,
  input  logic                              clr_i,
  output logic                              empty_o,
  output logic                              full_o,
  output logic [$clog2(els_p+1)-1:0]        credits_o
);

  localparam int idx_w  = $clog2(els_p);
  localparam int ptr_w  = idx_w + 1;
  localparam int cred_w = $clog2(els_p+1);

  // Pointers carry one extra wrap bit so full (distance els_p) and empty
  // (distance 0) are distinguishable; all differences are modulo 2*els_p.
  typedef logic [ptr_w-1:0] ptr_t;

  logic [data_width_p-1:0] mem [els_p];

  ptr_t wptr;
  ptr_t rptr;
  ptr_t cptr;
  ptr_t spec_occ;
  ptr_t tot_occ;
  ptr_t cptr_n;
  logic enq;

  // Status outputs depend on registered pointers only.
  assign spec_occ  = wptr - rptr;
  assign tot_occ   = wptr - cptr;
  assign full_o    = (tot_occ == ptr_t'(els_p));
  assign ready_o   = ~full_o;
  assign empty_o   = (spec_occ == '0);
  assign credits_o = cred_w'(els_p) - cred_w'(tot_occ);

  // A clear discards a same-cycle enqueue; inputs are ignored during reset.
  assign enq = v_i & ready_o & ~clr_i & ~reset_i;

  // Commit is applied before roll so a roll lands on the post-commit pointer.
  assign cptr_n = cptr + ptr_t'(deq_cnt_i);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else if (clr_i) begin
      rptr <= wptr;
      cptr <= wptr;
    end else begin
      cptr <= cptr_n;
      if (roll_i) begin
        rptr <= cptr_n;
      end else begin
        rptr <= rptr + ptr_t'(yumi_cnt_i);
      end
      if (enq) begin
        wptr <= wptr + ptr_t'(1);
      end
    end
  end

  // Storage is not reset; stale contents are masked by v_o.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wptr[idx_w-1:0]] <= data_i;
    end
  end

  // Lane k reads rptr+k; the idx_w-bit sum wraps around the array end.
  always_comb begin
    data_o = '0;
    v_o    = '0;
    for (int k = 0; k < lanes_p; k++) begin
      data_o[k*data_width_p +: data_width_p] = mem[rptr[idx_w-1:0] + idx_w'(k)];
      v_o[k] = (spec_occ > ptr_t'(k));
    end
  end

`ifndef SYNTHESIS
  // Issue may not exceed the valid lanes; a roll or clear overrides the issue count.
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    (!clr_i && !roll_i) |-> (ptr_t'(yumi_cnt_i) <= spec_occ && int'(yumi_cnt_i) <= lanes_p));

  // Commit may not pass the speculative pointer.
  a_deq_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    (!clr_i) |-> (ptr_t'(deq_cnt_i) <= (rptr - cptr) && int'(deq_cnt_i) <= lanes_p));

  // cptr <= rptr <= wptr in wrap-aware distance.
  a_ptr_order: assert property (@(posedge clk_i) disable iff (reset_i)
    ((rptr - cptr) <= tot_occ) && (tot_occ <= ptr_t'(els_p)));
`endif

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Purpose: randomized and directed self-checking bench for bp_be_issue_queue.
// Latency: checks outputs 1 time unit after each rising edge against an unbounded-counter model.
// Backpressure: model decides acceptance from its own occupancy, never from the DUT.
module tb_bp_be_issue_queue;

  localparam int dw    = 64;
  localparam int els   = 16;
  localparam int lanes = 2;

  logic            clk = 1'b0;
  logic            reset_i = 1'b1;
  logic [dw-1:0]   data_i = '0;
  logic            v_i = 1'b0;
  logic            ready_o;
  logic [lanes*dw-1:0] data_o;
  logic [lanes-1:0] v_o;
  logic [1:0]      yumi_cnt_i = '0;
  logic [1:0]      deq_cnt_i = '0;
  logic            roll_i = 1'b0;
  logic            clr_i = 1'b0;
  logic            empty_o;
  logic            full_o;
  logic [4:0]      credits_o;

  bp_be_issue_queue #(.data_width_p(dw), .els_p(els), .lanes_p(lanes)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .data_i     (data_i),
    .v_i        (v_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .v_o        (v_o),
    .yumi_cnt_i (yumi_cnt_i),
    .deq_cnt_i  (deq_cnt_i),
    .roll_i     (roll_i),
    .clr_i      (clr_i),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .credits_o  (credits_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: monotonically increasing entry counts, slot = count mod els.
  int w = 0;
  int r = 0;
  int c = 0;
  logic [dw-1:0] mm [els];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_all(input string tag);
    int spec;
    int occ;
    logic [lanes-1:0] exp_v;
    spec = w - r;
    occ  = w - c;
    exp_v = '0;
    for (int k = 0; k < lanes; k++) exp_v[k] = (spec > k);
    check({tag, ".empty"},   64'(empty_o),   64'(spec == 0));
    check({tag, ".full"},    64'(full_o),    64'(occ == els));
    check({tag, ".ready"},   64'(ready_o),   64'(occ < els));
    check({tag, ".credits"}, 64'(credits_o), 64'(els - occ));
    check({tag, ".v_o"},     64'(v_o),       64'(exp_v));
    for (int k = 0; k < lanes; k++)
      if (spec > k)
        check($sformatf("%s.lane%0d", tag, k), data_o[k*dw +: dw], mm[(r + k) % els]);
    check({tag, ".wptr"}, 64'(dut.wptr), 64'(w % (2*els)));
    check({tag, ".rptr"}, 64'(dut.rptr), 64'(r % (2*els)));
    check({tag, ".cptr"}, 64'(dut.cptr), 64'(c % (2*els)));
  endtask

  // Drive one cycle of inputs, advance the model by the queue rules, then check.
  task automatic cyc(input string tag, input logic v, input logic [dw-1:0] d,
                     input int y, input int dq, input logic rl, input logic cl);
    bit acc;
    v_i = v; data_i = d; yumi_cnt_i = 2'(y); deq_cnt_i = 2'(dq); roll_i = rl; clr_i = cl;
    acc = v && ((w - c) < els) && !cl;
    if (acc) mm[w % els] = d;
    if (cl) begin
      r = w;
      c = w;
    end else begin
      c = c + dq;
      r = rl ? c : r + y;
      if (acc) w = w + 1;
    end
    @(posedge clk);
    #1;
    v_i = 1'b0; yumi_cnt_i = '0; deq_cnt_i = '0; roll_i = 1'b0; clr_i = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [dw-1:0] rec;
    int spec;
    int cm;
    #2;
    check_all("reset");
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
    check_all("post_reset");

    // Fill/drain
    for (int i = 0; i < 16; i++) cyc("fill", 1'b1, dw'(i), 0, 0, 1'b0, 1'b0);
    check("fill.full_o", 64'(full_o), 64'd1);
    check("fill.credits_o", 64'(credits_o), 64'd0);
    cyc("fill17", 1'b1, 64'hAA, 0, 0, 1'b0, 1'b0);
    cyc("drain_yumi", 1'b0, '0, 2, 0, 1'b0, 1'b0);
    cyc("drain_deq", 1'b0, '0, 2, 2, 1'b0, 1'b0);
    check("drain.ready_o", 64'(ready_o), 64'd1);
    check("drain.credits_o", 64'(credits_o), 64'd2);
    cyc("clr0", 1'b0, '0, 0, 0, 1'b0, 1'b1);

    // Speculative replay
    for (int i = 0; i < 5; i++) cyc("replay_enq", 1'b1, 64'hA0 + dw'(i), 0, 0, 1'b0, 1'b0);
    check("replay.lane0_A", data_o[0 +: dw], 64'hA0);
    cyc("replay_y1", 1'b0, '0, 2, 0, 1'b0, 1'b0);
    check("replay.lane0_C", data_o[0 +: dw], 64'hA2);
    cyc("replay_y2", 1'b0, '0, 2, 0, 1'b0, 1'b0);
    cyc("replay_deq", 1'b0, '0, 0, 1, 1'b0, 1'b0);
    cyc("replay_roll", 1'b0, '0, 0, 0, 1'b1, 1'b0);
    check("replay.v_o", 64'(v_o), 64'h3);
    check("replay.lane0_B", data_o[0 +: dw], 64'hA1);
    check("replay.lane1_C", data_o[dw +: dw], 64'hA2);
    cyc("clr1", 1'b0, '0, 0, 0, 1'b0, 1'b1);

    // Wrap-around: align all pointers to slot 15
    while ((w % els) != 15) cyc("wrap_adv", 1'b1, 64'h55, 2 * int'(w - r >= 2), 0, 1'b0, 1'b0);
    cyc("wrap_clr", 1'b0, '0, 0, 0, 1'b0, 1'b1);
    cyc("wrap_x", 1'b1, 64'hC0FFEE, 0, 0, 1'b0, 1'b0);
    cyc("wrap_y", 1'b1, 64'hBEEF, 0, 0, 1'b0, 1'b0);
    check("wrap.lane1_mem0", 64'(dut.mem[0]), 64'hBEEF);
    check("wrap.lane1_Y", data_o[dw +: dw], 64'hBEEF);
    cyc("clr2", 1'b0, '0, 0, 0, 1'b0, 1'b1);

    // Simultaneous deq + roll + yumi + enqueue
    for (int i = 0; i < 4; i++) cyc("sim_enq", 1'b1, 64'hD0 + dw'(i), 0, 0, 1'b0, 1'b0);
    cyc("sim_issue", 1'b0, '0, 2, 0, 1'b0, 1'b0);
    cyc("sim_all", 1'b1, 64'h2222, 2, 1, 1'b1, 1'b0);
    check("sim.rptr_eq_cptr", 64'(dut.rptr), 64'(dut.cptr));
    check("sim.lane0", data_o[0 +: dw], 64'hD1);
    cyc("clr3", 1'b0, '0, 0, 0, 1'b0, 1'b1);

    // Clear with simultaneous enqueue
    for (int i = 0; i < 6; i++) cyc("clr_enq", 1'b1, 64'hE0 + dw'(i), 0, 0, 1'b0, 1'b0);
    cyc("clr_y2", 1'b0, '0, 2, 0, 1'b0, 1'b0);
    cyc("clr_y1", 1'b0, '0, 1, 0, 1'b0, 1'b0);
    cyc("clr_drop", 1'b1, 64'hDEAD, 0, 0, 1'b0, 1'b1);
    check("clr.credits_o", 64'(credits_o), 64'd16);
    check("clr.v_o", 64'(v_o), 64'd0);

    // Randomized traffic with legal issue/commit counts
    for (int n = 0; n < 3000; n++) begin
      spec = w - r;
      cm   = r - c;
      rec  = {$urandom, $urandom};
      cyc("rand", ($urandom_range(0, 3) != 0), rec,
          int'($urandom_range(0, min2(spec, lanes))),
          int'($urandom_range(0, min2(cm, lanes))),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 79) == 0));
    end

    // Async reset mid-cycle with 5 entries held
    cyc("ar_clr", 1'b0, '0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc("ar_enq", 1'b1, 64'hF0 + dw'(i), 0, 0, 1'b0, 1'b0);
    #2;
    reset_i = 1'b1;
    #1;
    w = 0; r = 0; c = 0;
    check_all("async_reset");
    @(posedge clk); #1;
    check_all("reset_held");
    reset_i = 1'b0;
    cyc("ar_first", 1'b1, 64'h1234, 0, 0, 1'b0, 1'b0);
    check("ar.mem0", 64'(dut.mem[0]), 64'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_be_issue_queue.md
# bp_be_issue_queue

Rollback-capable instruction queue between the FE queue handshake and BE dispatch. Generalises the single-entry yumi/deq/roll/clr FE queue protocol to `lanes_p` entries consumed per cycle with configurable depth and width. Keeps a speculative read pointer and a commit pointer, so issued-but-uncommitted entries can be replayed. Sits in the BE checker in front of the issue logic.

## Interface
- `data_width_p`, default 64: entry width in bits.
- `els_p`, default 16: queue depth; power of two, at least 4.
- `lanes_p`, default 2: maximum entries issued or committed per cycle; 1..4, with lanes_p ≤ els_p.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `data_i`  in  data_width_p  enqueue payload.
- `v_i`  in  1  enqueue valid; an enqueue occurs when v_i & ready_o.
- `ready_o`  out  1  queue can accept an entry; equals ~full_o.
- `data_o`  out  lanes_p*data_width_p  lane k occupies bits [k*data_width_p +: data_width_p] and holds mem[rptr+k].
- `v_o`  out  lanes_p  lane k valid when speculative occupancy > k; thermometer-coded.
- `yumi_cnt_i`  in  $clog2(lanes_p+1)  number of lanes consumed this cycle, lanes 0..n-1.
- `deq_cnt_i`  in  $clog2(lanes_p+1)  number of oldest entries committed this cycle.
- `roll_i`  in  1  restore the speculative pointer to the commit pointer.
- `clr_i`  in  1  discard all entries.
- `empty_o`  out  1  no speculative entries (rptr == wptr).
- `full_o`  out  1  wptr − cptr == els_p.
- `credits_o`  out  $clog2(els_p+1)  free slots, els_p − (wptr − cptr).

## Operation
- Storage is an els_p × data_width_p register array.
- Three pointers, `wptr`, `rptr` and `cptr`, each $clog2(els_p)+1 bits wide. The MSB is a wrap bit. All arithmetic is modulo 2·els_p, and array indexing uses the low bits.
- Invariant: cptr ≤ rptr ≤ wptr in wrap-aware distance.
- Enqueue: writes mem[wptr]; wptr += 1.
- Issue: rptr += yumi_cnt_i.
  - Legal only if yumi_cnt_i ≤ popcount(v_o). Violation is a simulation assertion failure; the RTL does not clamp.
- Commit: cptr += deq_cnt_i.
  - Legal only if deq_cnt_i ≤ rptr − cptr. Violation is an assertion failure.
  - Freed slots become credits.
- Roll: next rptr = next cptr, where next cptr already includes this cycle's deq_cnt_i. yumi_cnt_i is ignored in a roll cycle.
- Clear:
  - rptr and cptr are set to wptr.
  - A same-cycle enqueue is discarded and wptr is held.
  - yumi_cnt_i, deq_cnt_i and roll_i are ignored.
- Priority within one cycle: clr_i > roll_i > yumi_cnt_i. deq_cnt_i is applied in all non-clr cycles.
- An enqueue in the same cycle as a roll or deq is always accepted if ready_o was high.
- Lane reads wrap around the array end. Example with els_p=16 and rptr low bits = 15: lane 1 reads mem[0].

## Timing
- Reset (asynchronous assert) forces:
  - wptr = rptr = cptr = 0.
  - ready_o = 1, full_o = 0, empty_o = 1, v_o = 0, credits_o = els_p.
  - data_o is don't-care.
- Array contents are not reset.
- Enqueue to visibility: an entry enqueued at edge t appears on v_o/data_o after edge t. There is no same-cycle bypass.
- ready_o, full_o, empty_o, v_o and credits_o are pure functions of the registered pointers and have no combinational path from any input.
- A commit while full raises ready_o only after the edge.
- Issue, commit, roll and clr take effect at the next edge. Outputs reflect the new state in the following cycle.
- Throughput: 1 enqueue per cycle and up to lanes_p issues plus lanes_p commits per cycle.
- Reset asserted mid-operation drops all entries immediately. Inputs are ignored while reset_i is high.

## Test plan
- **Fill/drain** (els_p=16, lanes_p=2):
  - Enqueue 16 entries with data 0x0..0xF → full_o=1, ready_o=0, credits_o=0.
  - A 17th v_i is not accepted.
  - yumi 2 and deq 2 → next cycle ready_o=1, credits_o=2.
- **Speculative replay**:
  - Enqueue A..E; yumi 2 twice, so lanes read A,B then C,D.
  - deq 1, then roll → v_o=2'b11 with data_o lanes = B, C.
- **Wrap-around**:
  - Advance all pointers to 15, then enqueue X, Y.
  - Lane 0 = X from mem[15]; lane 1 = Y from mem[0]; the wrap bit toggles.
- **Simultaneous events**:
  - With 4 entries, 2 issued and 0 committed, apply deq 1 + roll + yumi 2 + enqueue Z in one cycle.
  - Next cycle: rptr = cptr = 1, 4 speculative entries including Z, yumi ignored.
- **Clear**:
  - With 6 entries and 3 issued, apply clr_i together with v_i=1.
  - Next cycle: empty_o=1, credits_o=16, v_o=0, and the enqueued entry is dropped.
- **Async reset**:
  - Assert reset_i mid-cycle while the queue holds 5 entries.
  - Outputs go to reset values before the next edge, and after release the first enqueue lands at mem[0].
